sram_cache_controller: RTL
==========================

// Module: sram_cache_controller
// PURPOSE
//  Direct-mapped, write-through, no-write-allocate data cache between the memory stage and the SRAM controller.
//  Read hits return data in the same cycle without stalling.
//  Read misses fetch a 64-bit line (two words) from the SRAM controller.
//  Writes always go through to SRAM. freeze stalls the pipeline (same role as SRAMFreeze) while SRAM is busy.
// PARAMETERS
//  SETS         64  number of cache lines (power of 2); INDEX_W = log2(SETS)
//  BYTE_ADDR_W  19  significant byte-address bits (512 KB SRAM); TAG_W = BYTE_ADDR_W-3-INDEX_W
// PORTS
//  clk                 in   1   single clock, rising edge
//  rst                 in   1   asynchronous, active-low reset
//  memoryReadEnabled   in   1   CPU load request (held until freeze=0)
//  memoryWriteEnabled  in   1   CPU store request (held until freeze=0)
//  address             in   32  CPU byte address (aluResult); bits [1:0] ignored
//  writeData           in   32  store data (valRm)
//  readData            out  32  load data, valid when memoryReadEnabled & ~freeze
//  freeze              out  1   1 = request not completed this cycle; pipeline holds
//  sramReadEn          out  1   line-fill request to SRAM controller
//  sramWriteEn         out  1   word write request to SRAM controller
//  sramAddress         out  32  line address (read, [2:0]=0) or word address (write, [1:0]=0)
//  sramWriteData       out  32  write data to SRAM controller
//  sramReadData        in   64  filled line: [31:0]=word at addr, [63:32]=word at addr+4
//  sramReady           in   1   one-cycle pulse: current SRAM transaction done
// BEHAVIOUR
//  Address split: word=addr[2], index=addr[INDEX_W+2:3], tag=addr[BYTE_ADDR_W-1:INDEX_W+3].
//  hit = valid[index] & (tagArray[index]==tag); combinational.
//  FSM states: IDLE, READ_MISS, WRITE_THROUGH.
//  IDLE:
//   - read & hit: readData=selected word, freeze=0, stay IDLE.
//   - read & miss: freeze=1, go READ_MISS.
//   - write: freeze=1, go WRITE_THROUGH.
//   - read & write both 1: treated as write.
//   - neither: freeze=0.
//  READ_MISS:
//   - sramReadEn=1 and sramAddress={address[31:3],3'b0}, held until sramReady; freeze=1 throughout.
//   - On sramReady: write line, tag and valid=1 at index; go IDLE. Next cycle hits, freeze=0.
//   - Load latency = SRAM latency + 1 cycle.
//  WRITE_THROUGH:
//   - sramWriteEn=1, sramAddress={address[31:2],2'b0}, sramWriteData=writeData, held until sramReady.
//   - freeze = ~sramReady, so the store retires in the sramReady cycle.
//   - In that cycle, if hit: update the addressed word only. On miss, no allocate.
//   - Go IDLE.
//  sramReady outside READ_MISS/WRITE_THROUGH is ignored.
//  sramReadEn and sramWriteEn are never both 1.
//  Reset (async, any state, including mid-transaction):
//   - state=IDLE, all valid bits=0, sramReadEn=sramWriteEn=0, sramAddress=0, sramWriteData=0.
//   - freeze/readData follow IDLE decode (0 with no request).
//   - An in-flight SRAM transaction is abandoned; the SRAM controller is reset by the same rst.
//  Data/tag arrays are not reset. Only valid bits are reset.
//  Conflict: addresses equal modulo SETS*8 bytes share a line; a fill overwrites it.
// STRUCTURE
//  Shared package cache_pkg: FSM state encodings, SETS/BYTE_ADDR_W defaults, derived INDEX_W/TAG_W.
//  Sub-module cache_line_array:
//   - valid (async-clear flops), tag and 2x32 data storage.
//   - 1 combinational read port; write port supports full-line fill or single-word write.
//  Top holds the FSM, hit logic, output muxing and SRAM handshake.
// TESTING
//  1 Reset, read 0x400, SRAM model replies 0xAAAA0001/0xBBBB0002 after 5 cycles:
//    -> freeze=1 for 6 cycles, then readData=0xAAAA0001; exactly one sramReadEn transaction at 0x400.
//  2 Then read 0x404 -> readData=0xBBBB0002 same cycle, freeze=0, no SRAM request.
//  3 Write 0x12345678 to 0x400 (hit):
//    -> sramWriteEn at 0x400 until ready; freeze drops in the ready cycle; read 0x400 -> 0x12345678 with no fill.
//  4 Write to 0x800 (miss), then read 0x800:
//    -> write goes to SRAM and no line is allocated; the read misses and fills.
//  5 Read 0x400 then 0x600 (same index, SETS=64):
//    -> second is a miss and evicts; re-read of 0x400 misses again.
//  6 Assert rst mid READ_MISS:
//    -> sramReadEn=0 immediately; after release, read 0x400 misses (valid cleared).

Source files
------------

// File: rtl/cache_pkg.sv
// Shared definitions for the direct-mapped write-through data cache:
// FSM state encoding, default geometry and derived field widths.
package cache_pkg;

  localparam int unsigned SETS_DEFAULT        = 64;
  localparam int unsigned BYTE_ADDR_W_DEFAULT = 19;
  localparam int unsigned INDEX_W_DEFAULT     = $clog2(SETS_DEFAULT);
  localparam int unsigned TAG_W_DEFAULT       = BYTE_ADDR_W_DEFAULT - 3 - INDEX_W_DEFAULT;

  typedef enum logic [1:0] {
    IDLE          = 2'd0,
    READ_MISS     = 2'd1,
    WRITE_THROUGH = 2'd2
  } cache_state_e;

  // Tag width left after removing the 8-byte line offset and the set index.
  function automatic int unsigned tag_width(input int unsigned sets,
                                            input int unsigned byte_addr_w);
    return byte_addr_w - 3 - $clog2(sets);
  endfunction

endpackage

// File: rtl/cache_line_array.sv
// Line storage for the data cache: resettable valid bits, tags and two
// 32-bit words per line. One combinational read port, one write port.
module cache_line_array
  import cache_pkg::*;
#(
  parameter int unsigned SETS    = SETS_DEFAULT,
  parameter int unsigned INDEX_W = INDEX_W_DEFAULT,
  parameter int unsigned TAG_W   = TAG_W_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [INDEX_W-1:0] rd_index,
  output logic               rd_valid,
  output logic [TAG_W-1:0]   rd_tag,
  output logic [63:0]        rd_line,
  input  logic               fill_en,
  input  logic               word_en,
  input  logic [INDEX_W-1:0] wr_index,
  input  logic               wr_word_sel,
  input  logic [TAG_W-1:0]   wr_tag,
  input  logic [63:0]        fill_line,
  input  logic [31:0]        wr_word
);

  logic [SETS-1:0]  valid_q;
  logic [TAG_W-1:0] tag_q  [SETS];
  logic [31:0]      data_lo[SETS];
  logic [31:0]      data_hi[SETS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else if (fill_en) begin
      valid_q[wr_index] <= 1'b1;
    end
  end

  // Tags and data are deliberately left unreset; valid gates every use.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_q[wr_index]   <= wr_tag;
      data_lo[wr_index] <= fill_line[31:0];
      data_hi[wr_index] <= fill_line[63:32];
    end else if (word_en) begin
      if (wr_word_sel) begin
        data_hi[wr_index] <= wr_word;
      end else begin
        data_lo[wr_index] <= wr_word;
      end
    end
  end

  assign rd_valid = valid_q[rd_index];
  assign rd_tag   = tag_q[rd_index];
  assign rd_line  = {data_hi[rd_index], data_lo[rd_index]};

endmodule

// File: rtl/sram_cache_controller.sv
// Direct-mapped, write-through, no-write-allocate data cache sitting between
// the memory stage and the SRAM controller; freeze stalls the pipeline.
module sram_cache_controller
  import cache_pkg::*;
#(
  parameter int unsigned SETS        = SETS_DEFAULT,
  parameter int unsigned BYTE_ADDR_W = BYTE_ADDR_W_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memoryReadEnabled,
  input  logic        memoryWriteEnabled,
  input  logic [31:0] address,
  input  logic [31:0] writeData,
  output logic [31:0] readData,
  output logic        freeze,
  output logic        sramReadEn,
  output logic        sramWriteEn,
  output logic [31:0] sramAddress,
  output logic [31:0] sramWriteData,
  input  logic [63:0] sramReadData,
  input  logic        sramReady
);

  localparam int unsigned INDEX_W = $clog2(SETS);
  localparam int unsigned TAG_W   = tag_width(SETS, BYTE_ADDR_W);

  cache_state_e       state;
  logic [INDEX_W-1:0] index;
  logic [TAG_W-1:0]   tag;
  logic               word_sel;
  logic               line_valid;
  logic [TAG_W-1:0]   line_tag;
  logic [63:0]        line_data;
  logic               hit;
  logic [31:0]        hit_word;
  logic               fill_en;
  logic               word_en;

  assign word_sel = address[2];
  assign index    = address[INDEX_W+2:3];
  assign tag      = address[BYTE_ADDR_W-1:INDEX_W+3];
  assign hit      = line_valid && (line_tag == tag);
  assign hit_word = word_sel ? line_data[63:32] : line_data[31:0];

  // The CPU holds address/writeData until freeze drops, so the array write
  // in the sramReady cycle can use the live address fields.
  assign fill_en = (state == READ_MISS) && sramReady;
  assign word_en = (state == WRITE_THROUGH) && sramReady && hit;

  cache_line_array #(
    .SETS    (SETS),
    .INDEX_W (INDEX_W),
    .TAG_W   (TAG_W)
  ) u_lines (
    .clk         (clk),
    .rst_n       (rst),
    .rd_index    (index),
    .rd_valid    (line_valid),
    .rd_tag      (line_tag),
    .rd_line     (line_data),
    .fill_en     (fill_en),
    .word_en     (word_en),
    .wr_index    (index),
    .wr_word_sel (word_sel),
    .wr_tag      (tag),
    .fill_line   (sramReadData),
    .wr_word     (writeData)
  );

  always_comb begin
    freeze   = 1'b0;
    readData = '0;
    case (state)
      IDLE: begin
        if (memoryWriteEnabled) begin
          freeze = 1'b1;
        end else if (memoryReadEnabled) begin
          if (hit) begin
            readData = hit_word;
          end else begin
            freeze = 1'b1;
          end
        end
      end
      READ_MISS:     freeze = 1'b1;
      WRITE_THROUGH: freeze = ~sramReady;
      default:       freeze = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      sramReadEn    <= 1'b0;
      sramWriteEn   <= 1'b0;
      sramAddress   <= '0;
      sramWriteData <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (memoryWriteEnabled) begin
            state         <= WRITE_THROUGH;
            sramWriteEn   <= 1'b1;
            sramAddress   <= {address[31:2], 2'b00};
            sramWriteData <= writeData;
          end else if (memoryReadEnabled && !hit) begin
            state       <= READ_MISS;
            sramReadEn  <= 1'b1;
            sramAddress <= {address[31:3], 3'b000};
          end
        end
        READ_MISS: begin
          if (sramReady) begin
            state      <= IDLE;
            sramReadEn <= 1'b0;
          end
        end
        WRITE_THROUGH: begin
          if (sramReady) begin
            state       <= IDLE;
            sramWriteEn <= 1'b0;
          end
        end
        default: begin
          state       <= IDLE;
          sramReadEn  <= 1'b0;
          sramWriteEn <= 1'b0;
        end
      endcase
    end
  end

endmodule
